// File: rtl/alu_result_collector_if.sv
// ---------------------------------------------------------------------------
// alu_result_collector_if
//
// Bundles every signal between the ALU issue side, the result consumer and
// the alu_result_collector. clk and rst are not part of the bundle.
//
//   master : the environment side. It drives the issue/ALU-result inputs and
//            out_ready, and observes the FIFO head and status.
//   slave  : the collector side (alu_result_collector).
//
// Signals
//   issue_valid   op presented to the ALU inputs this cycle
//   issue_opcode  opcode of the issued op
//   alu_y         ALU result Y (NBITS+2 wide)
//   alu_co        ALU carry-out
//   out_valid     FIFO head holds a result
//   out_ready     consumer accepts the head this cycle
//   out_opcode    head opcode
//   out_y         head result
//   out_co        head carry
//   count         entries stored
//   overflow      sticky: a result was dropped
//   drop_cnt      dropped results, saturating at 255
// ---------------------------------------------------------------------------
interface alu_result_collector_if #(
    parameter int NBITS = 7,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic [2:0]       issue_opcode;
    logic [NBITS+1:0] alu_y;
    logic             alu_co;

    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_opcode;
    logic [NBITS+1:0] out_y;
    logic             out_co;

    logic [CW-1:0]    count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    modport master (
        output issue_valid,
        output issue_opcode,
        output alu_y,
        output alu_co,
        output out_ready,
        input  out_valid,
        input  out_opcode,
        input  out_y,
        input  out_co,
        input  count,
        input  overflow,
        input  drop_cnt
    );

    modport slave (
        input  issue_valid,
        input  issue_opcode,
        input  alu_y,
        input  alu_co,
        input  out_ready,
        output out_valid,
        output out_opcode,
        output out_y,
        output out_co,
        output count,
        output overflow,
        output drop_cnt
    );
endinterface

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
//
// Receiving end of the pipelined ALU. Every op issued to the ALU is tracked
// through a tag delay line whose depth matches the ALU latency; when the tag
// reaches the last stage the ALU result {alu_y, alu_co} of that cycle is
// captured together with the tagged opcode and written into a first-word-
// fall-through FIFO. A valid/ready consumer drains the FIFO in issue order.
//
// Parameters
//   NBITS  ALU operand MSB index; result is NBITS+2 wide
//   LAT    ALU result latency in cycles (0 = combinational ALU)
//   DEPTH  result FIFO entries (>= 2)
//
// Ports
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   alu_result_collector_if.slave (issue, result, FIFO head, status)
//
// Behaviour summary
//   - Reset clears the tag line (in-flight ops are discarded), empties the
//     FIFO and clears overflow/drop_cnt. An issue during reset is ignored.
//   - A capture becomes visible at the head the cycle after it is written.
//   - Push and pop in the same cycle are both performed, also when full.
//     A push into a full FIFO without a pop is dropped, setting the sticky
//     overflow flag and incrementing the saturating drop counter.
//   - out_* show the head entry and read 0 while the FIFO is empty. They are
//     derived from registered state only, so out_ready never reaches them
//     combinationally.
// ---------------------------------------------------------------------------
module alu_result_collector #(
    parameter int NBITS = 7,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_result_collector_if.slave  bus
);
    localparam int YW = NBITS + 2;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]    opcode;
        logic          co;
        logic [YW-1:0] y;
    } entry_t;

    // -----------------------------------------------------------------------
    // Tag delay line: {valid, opcode} travels LAT stages so that it lines up
    // with the ALU result of the same op.
    // -----------------------------------------------------------------------
    logic       cap_valid;
    logic [2:0] cap_opcode;

    generate
        if (LAT == 0) begin : g_comb
            // Combinational ALU: the result belongs to the op issued in the
            // same cycle. Gating with rst keeps an issue during reset out.
            assign cap_valid  = bus.issue_valid & ~rst;
            assign cap_opcode = bus.issue_opcode;
        end else begin : g_pipe
            for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
                logic       valid_reg;
                logic [2:0] opcode_reg;

                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            valid_reg  <= 1'b0;
                            opcode_reg <= 3'd0;
                        end else begin
                            valid_reg  <= bus.issue_valid;
                            opcode_reg <= bus.issue_opcode;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            valid_reg  <= 1'b0;
                            opcode_reg <= 3'd0;
                        end else begin
                            valid_reg  <= g_stage[gi-1].valid_reg;
                            opcode_reg <= g_stage[gi-1].opcode_reg;
                        end
                    end
                end
            end

            assign cap_valid  = g_stage[LAT-1].valid_reg;
            assign cap_opcode = g_stage[LAT-1].opcode_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    entry_t        mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg,   rd_ptr_next;
    logic [CW-1:0] count_reg,    count_next;
    logic          overflow_reg, overflow_next;
    logic [7:0]    drop_cnt_reg, drop_cnt_next;

    logic   empty;
    logic   full;
    logic   push;
    logic   pop;
    logic   write_en;
    logic   drop;
    entry_t cap_entry;
    entry_t head_entry;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // pop only depends on the registered count, so an entry pushed into an
    // empty FIFO cannot be popped in the cycle it is written.
    assign pop  = ~empty & bus.out_ready & ~rst;
    assign push = cap_valid & ~rst;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign write_en = push & (~full | pop);
    assign drop     = push & full & ~pop;

    assign cap_entry.opcode = cap_opcode;
    assign cap_entry.co     = bus.alu_co;
    assign cap_entry.y      = bus.alu_y;

    // Storage array: no reset needed, the head is qualified by count.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_reg] <= cap_entry;
        end
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;

        if (write_en) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end

        if (write_en && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!write_en && pop) begin
            count_next = count_reg - 1'b1;
        end

        if (drop) begin
            overflow_next = 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Head presentation: zeroed while empty.
    // -----------------------------------------------------------------------
    always_comb begin
        head_entry = '0;
        if (!empty) begin
            head_entry = mem[rd_ptr_reg];
        end
    end

    assign bus.out_valid  = ~empty;
    assign bus.out_opcode = head_entry.opcode;
    assign bus.out_co     = head_entry.co;
    assign bus.out_y      = head_entry.y;
    assign bus.count      = count_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.drop_cnt   = drop_cnt_reg;

endmodule
